// File: rtl/dma_cmd_sequencer_if.sv
// Command port and AXI4-Lite register bus between the DMA command sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the command source plus register slave.
interface dma_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_addr;
    logic [25:0] cmd_len;
    logic        busy;
    logic        done;
    logic        err;

    logic [9:0]  s_axi_lite_awaddr;
    logic        s_axi_lite_awvalid;
    logic        s_axi_lite_awready;
    logic [31:0] s_axi_lite_wdata;
    logic        s_axi_lite_wvalid;
    logic        s_axi_lite_wready;
    logic [1:0]  s_axi_lite_bresp;
    logic        s_axi_lite_bvalid;
    logic        s_axi_lite_bready;
    logic [9:0]  s_axi_lite_araddr;
    logic        s_axi_lite_arvalid;
    logic        s_axi_lite_arready;
    logic [31:0] s_axi_lite_rdata;
    logic [1:0]  s_axi_lite_rresp;
    logic        s_axi_lite_rvalid;
    logic        s_axi_lite_rready;

    modport master (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
        output cmd_ready, busy, done, err,
        output s_axi_lite_awaddr, s_axi_lite_awvalid,
        input  s_axi_lite_awready,
        output s_axi_lite_wdata, s_axi_lite_wvalid,
        input  s_axi_lite_wready,
        input  s_axi_lite_bresp, s_axi_lite_bvalid,
        output s_axi_lite_bready,
        output s_axi_lite_araddr, s_axi_lite_arvalid,
        input  s_axi_lite_arready,
        input  s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid,
        output s_axi_lite_rready
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len,
        input  cmd_ready, busy, done, err,
        input  s_axi_lite_awaddr, s_axi_lite_awvalid,
        output s_axi_lite_awready,
        input  s_axi_lite_wdata, s_axi_lite_wvalid,
        output s_axi_lite_wready,
        output s_axi_lite_bresp, s_axi_lite_bvalid,
        input  s_axi_lite_bready,
        input  s_axi_lite_araddr, s_axi_lite_arvalid,
        output s_axi_lite_arready,
        output s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid,
        input  s_axi_lite_rready
    );
endinterface

// File: rtl/dma_cmd_sequencer.sv
// Programs an AXI DMA channel (CR, SA/DA, LEN) over AXI4-Lite, then polls SR every POLL_GAP cycles until halt/idle or error.
// One register transaction in flight at a time; any slave ready may stall indefinitely with address/data held stable.
module dma_cmd_sequencer #(
    parameter int POLL_GAP = 10
) (
    input  logic               clk,
    input  logic               rst,
    dma_cmd_sequencer_if.master bus
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, WR_CR, WR_ADDR, WR_LEN, RD_SR, WAIT_GAP, FINISH
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_dir;
    logic [31:0] r_addr;
    logic [25:0] r_len;

    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_aw_done;
    logic        r_w_done;
    logic [9:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic        r_arvalid;
    logic        r_rready;
    logic [9:0]  r_araddr;
    logic        r_err;
    logic [GAP_W-1:0] r_gap_cnt;

    logic        w_accept;
    logic        w_err_set;
    logic        w_wr_start;
    logic        w_rd_start;
    logic        w_b_done;
    logic        w_r_done;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_dir_sel;
    logic        w_sr_err;
    logic        w_sr_halt;
    logic [9:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [9:0]  w_sr_addr;
    logic        w_unused;

    assign w_b_done  = r_bready & bus.s_axi_lite_bvalid;
    assign w_r_done  = r_rready & bus.s_axi_lite_rvalid;
    assign w_aw_fin  = r_aw_done | (r_awvalid & bus.s_axi_lite_awready);
    assign w_w_fin   = r_w_done  | (r_wvalid  & bus.s_axi_lite_wready);
    // The CR write is set up in the same cycle the command is accepted, before r_dir is loaded.
    assign w_dir_sel = (r_state == IDLE) ? bus.cmd_dir : r_dir;
    assign w_sr_err  = (bus.s_axi_lite_rresp != 2'b00) | (|bus.s_axi_lite_rdata[6:4]);
    assign w_sr_halt = bus.s_axi_lite_rdata[1] | bus.s_axi_lite_rdata[0];
    assign w_sr_addr = r_dir ? 10'h034 : 10'h004;
    assign w_unused  = ^{bus.s_axi_lite_rdata[31:7], bus.s_axi_lite_rdata[3:2]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        w_wr_start  = 1'b0;
        w_rd_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    if (bus.cmd_len == 26'd0) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_state_nxt = WR_CR;
                        w_wr_start  = 1'b1;
                    end
                end
            end
            WR_CR, WR_ADDR, WR_LEN: begin
                if (w_b_done) begin
                    if (bus.s_axi_lite_bresp != 2'b00) begin
                        w_state_nxt = IDLE;
                        w_err_set   = 1'b1;
                    end else if (r_state == WR_CR) begin
                        w_state_nxt = WR_ADDR;
                        w_wr_start  = 1'b1;
                    end else if (r_state == WR_ADDR) begin
                        w_state_nxt = WR_LEN;
                        w_wr_start  = 1'b1;
                    end else begin
                        w_state_nxt = RD_SR;
                        w_rd_start  = 1'b1;
                    end
                end
            end
            RD_SR: begin
                if (w_r_done) begin
                    if (w_sr_err) begin
                        w_state_nxt = IDLE;
                        w_err_set   = 1'b1;
                    end else if (w_sr_halt) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt = WAIT_GAP;
                    end
                end
            end
            WAIT_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = RD_SR;
                    w_rd_start  = 1'b1;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // LEN goes last: writing it is what kicks off the DMA engine.
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        case (w_state_nxt)
            WR_CR: begin
                w_wr_addr = w_dir_sel ? 10'h030 : 10'h000;
                w_wr_data = 32'h0000_0001;
            end
            WR_ADDR: begin
                w_wr_addr = w_dir_sel ? 10'h048 : 10'h018;
                w_wr_data = r_addr;
            end
            WR_LEN: begin
                w_wr_addr = w_dir_sel ? 10'h058 : 10'h028;
                w_wr_data = {6'b0, r_len};
            end
            default: begin
                w_wr_addr = '0;
                w_wr_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_err     <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_accept) begin
                r_dir  <= bus.cmd_dir;
                r_addr <= bus.cmd_addr;
                r_len  <= bus.cmd_len;
            end
            if (r_awvalid && bus.s_axi_lite_awready) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (r_wvalid && bus.s_axi_lite_wready) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
            if (w_aw_fin && w_w_fin && !r_bready)
                r_bready <= 1'b1;
            if (w_b_done) begin
                r_bready  <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_wr_start) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= w_wr_addr;
                r_wdata   <= w_wr_data;
            end
            if (r_arvalid && bus.s_axi_lite_arready)
                r_arvalid <= 1'b0;
            if (w_r_done)
                r_rready <= 1'b0;
            if (w_rd_start) begin
                r_arvalid <= 1'b1;
                r_rready  <= 1'b1;
                r_araddr  <= w_sr_addr;
            end
            if (r_state == WAIT_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                     r_gap_cnt <= '0;
        end
    end

    assign bus.cmd_ready          = (r_state == IDLE);
    assign bus.busy               = (r_state != IDLE);
    assign bus.done               = (r_state == FINISH);
    assign bus.err                = r_err;
    assign bus.s_axi_lite_awaddr  = r_awaddr;
    assign bus.s_axi_lite_awvalid = r_awvalid;
    assign bus.s_axi_lite_wdata   = r_wdata;
    assign bus.s_axi_lite_wvalid  = r_wvalid;
    assign bus.s_axi_lite_bready  = r_bready;
    assign bus.s_axi_lite_araddr  = r_araddr;
    assign bus.s_axi_lite_arvalid = r_arvalid;
    assign bus.s_axi_lite_rready  = r_rready;

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer: table of command scenarios against a small AXI4-Lite slave,
// plus hand-written reset and mid-handshake reset sequences.
module tb_dma_cmd_sequencer;

    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_cmd_sequencer_if bus();

    dma_cmd_sequencer #(.POLL_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Packed arrays below are written highest index first: {item2, item1, item0}.
    typedef struct packed {
        logic             dir;
        logic [31:0]      addr;
        logic [25:0]      len;
        int               aw_dly;
        int               berr_idx;
        logic [2:0][31:0] sr;
        int               exp_nwr;
        logic [2:0][9:0]  exp_wa;
        logic [2:0][31:0] exp_wd;
        int               exp_nrd;
        logic [9:0]       exp_ra;
        int               exp_rd_gap;
        int               exp_aw_hi;
        int               exp_w_hi;
        int               exp_done;
        int               exp_err;
    } vec_t;

    vec_t vecs [7];

    int n_chk  = 0;
    int n_fail = 0;

    // Slave configuration and logs
    int               aw_dly = 0;
    int               berr_idx = -1;
    logic [2:0][31:0] sr_cfg = '0;
    int               aw_cnt = 0;
    int               rd_idx = 0;
    bit               ar_pend = 0;
    logic [9:0]       wa_log [8];
    logic [31:0]      wd_log [8];
    logic [9:0]       ra_log [8];
    int               ra_cyc [8];
    int               n_wa = 0, n_wd = 0, n_ra = 0;
    int               aw_hi0 = 0, w_hi0 = 0;
    int               done_cnt = 0, err_cnt = 0;
    int               viol_de = 0, viol_busy = 0, viol_ovl = 0, viol_b = 0, viol_stab = 0;
    logic             prev_aw = 1'b0, prev_w = 1'b0;
    logic [9:0]       prev_awaddr = '0;
    logic [31:0]      prev_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave and protocol monitor, all evaluated away from the rising edge.
    initial begin
        bus.s_axi_lite_awready = 1'b0;
        bus.s_axi_lite_wready  = 1'b0;
        bus.s_axi_lite_bvalid  = 1'b0;
        bus.s_axi_lite_bresp   = 2'b00;
        bus.s_axi_lite_arready = 1'b0;
        bus.s_axi_lite_rvalid  = 1'b0;
        bus.s_axi_lite_rdata   = '0;
        bus.s_axi_lite_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.err)  err_cnt++;
            if (bus.done && bus.err) viol_de++;
            if (bus.busy === bus.cmd_ready) viol_busy++;
            if ((bus.s_axi_lite_awvalid || bus.s_axi_lite_wvalid || bus.s_axi_lite_bready) &&
                (bus.s_axi_lite_arvalid || bus.s_axi_lite_rready)) viol_ovl++;
            if (bus.s_axi_lite_bready && (bus.s_axi_lite_awvalid || bus.s_axi_lite_wvalid)) viol_b++;
            if (prev_aw && bus.s_axi_lite_awvalid && bus.s_axi_lite_awaddr != prev_awaddr) viol_stab++;
            if (prev_w && bus.s_axi_lite_wvalid && bus.s_axi_lite_wdata != prev_wdata) viol_stab++;
            prev_aw     = bus.s_axi_lite_awvalid;
            prev_w      = bus.s_axi_lite_wvalid;
            prev_awaddr = bus.s_axi_lite_awaddr;
            prev_wdata  = bus.s_axi_lite_wdata;
            if (bus.s_axi_lite_awvalid && n_wa == 0) aw_hi0++;
            if (bus.s_axi_lite_wvalid && n_wd == 0)  w_hi0++;

            if (bus.s_axi_lite_awvalid && !bus.s_axi_lite_awready) begin
                if (aw_cnt >= aw_dly) begin
                    bus.s_axi_lite_awready = 1'b1;
                    if (n_wa < 8) wa_log[n_wa] = bus.s_axi_lite_awaddr;
                    n_wa++;
                    aw_cnt = 0;
                end else begin
                    aw_cnt++;
                end
            end else begin
                bus.s_axi_lite_awready = 1'b0;
                aw_cnt = 0;
            end

            if (bus.s_axi_lite_wvalid && !bus.s_axi_lite_wready) begin
                bus.s_axi_lite_wready = 1'b1;
                if (n_wd < 8) wd_log[n_wd] = bus.s_axi_lite_wdata;
                n_wd++;
            end else begin
                bus.s_axi_lite_wready = 1'b0;
            end

            if (bus.s_axi_lite_bvalid) begin
                bus.s_axi_lite_bvalid = 1'b0;
            end else if (bus.s_axi_lite_bready) begin
                bus.s_axi_lite_bvalid = 1'b1;
                bus.s_axi_lite_bresp  = (n_wa - 1 == berr_idx) ? 2'b10 : 2'b00;
            end

            if (bus.s_axi_lite_rvalid) begin
                bus.s_axi_lite_rvalid = 1'b0;
            end else if (ar_pend) begin
                bus.s_axi_lite_rvalid = 1'b1;
                bus.s_axi_lite_rresp  = 2'b00;
                bus.s_axi_lite_rdata  = (rd_idx < 3) ? sr_cfg[rd_idx] : 32'h1;
                rd_idx++;
                ar_pend = 0;
            end
            if (bus.s_axi_lite_arvalid && !bus.s_axi_lite_arready) begin
                bus.s_axi_lite_arready = 1'b1;
                if (n_ra < 8) begin
                    ra_log[n_ra] = bus.s_axi_lite_araddr;
                    ra_cyc[n_ra] = cyc;
                end
                n_ra++;
                ar_pend = 1;
            end else begin
                bus.s_axi_lite_arready = 1'b0;
            end
        end
    end

    task automatic clear_logs(input int dly, input int bidx, input logic [2:0][31:0] sr);
        aw_dly = dly; berr_idx = bidx; sr_cfg = sr;
        n_wa = 0; n_wd = 0; n_ra = 0; rd_idx = 0;
        aw_hi0 = 0; w_hi0 = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic send_cmd(input logic dir, input logic [31:0] addr, input logic [25:0] len);
        bus.cmd_dir   = dir;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        // Scramble the inputs after acceptance so any use of unlatched values shows up.
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = ~dir;
        bus.cmd_addr  = 32'hDEAD_BEEF;
        bus.cmd_len   = '1;
    endtask

    task automatic run_vec(input int vi, input string tag);
        vec_t v;
        int   t;
        v = vecs[vi];
        clear_logs(v.aw_dly, v.berr_idx, v.sr);
        send_cmd(v.dir, v.addr, v.len);
        t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s completion", tag), (done_cnt + err_cnt > 0), 1'b1);
        repeat (8) @(negedge clk);
        chk($sformatf("%s aw count", tag), n_wa, v.exp_nwr);
        chk($sformatf("%s w count", tag),  n_wd, v.exp_nwr);
        for (int k = 0; k < v.exp_nwr && k < n_wa && k < n_wd; k++) begin
            chk($sformatf("%s awaddr[%0d]", tag, k), wa_log[k], v.exp_wa[k]);
            chk($sformatf("%s wdata[%0d]", tag, k),  wd_log[k], v.exp_wd[k]);
        end
        chk($sformatf("%s ar count", tag), n_ra, v.exp_nrd);
        for (int k = 0; k < v.exp_nrd && k < n_ra; k++)
            chk($sformatf("%s araddr[%0d]", tag, k), ra_log[k], v.exp_ra);
        if (v.exp_rd_gap != 0 && n_ra >= 3) begin
            chk($sformatf("%s poll spacing 0-1", tag), ra_cyc[1] - ra_cyc[0], v.exp_rd_gap);
            chk($sformatf("%s poll spacing 1-2", tag), ra_cyc[2] - ra_cyc[1], v.exp_rd_gap);
        end
        chk($sformatf("%s first awvalid cycles", tag), aw_hi0, v.exp_aw_hi);
        chk($sformatf("%s first wvalid cycles", tag),  w_hi0,  v.exp_w_hi);
        chk($sformatf("%s done cycles", tag), done_cnt, v.exp_done);
        chk($sformatf("%s err cycles", tag),  err_cnt,  v.exp_err);
        chk($sformatf("%s cmd_ready after", tag), bus.cmd_ready, 1'b1);
        chk($sformatf("%s busy after", tag),      bus.busy,      1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;

        // Scenario table. Read spacing with POLL_GAP=4: AR, R, 4 idle cycles, next AR -> 6 cycles apart.
        vecs[0] = '{dir:1'b1, addr:32'h1000_0000, len:26'h400, aw_dly:0, berr_idx:-1,
                    sr:{32'h0, 32'h0, 32'h2}, exp_nwr:3,
                    exp_wa:{10'h058, 10'h048, 10'h030}, exp_wd:{32'h400, 32'h1000_0000, 32'h1},
                    exp_nrd:1, exp_ra:10'h034, exp_rd_gap:0, exp_aw_hi:1, exp_w_hi:1, exp_done:1, exp_err:0};
        vecs[1] = '{dir:1'b0, addr:32'h2000_0040, len:26'h80, aw_dly:0, berr_idx:-1,
                    sr:{32'h1, 32'h0, 32'h0}, exp_nwr:3,
                    exp_wa:{10'h028, 10'h018, 10'h000}, exp_wd:{32'h80, 32'h2000_0040, 32'h1},
                    exp_nrd:3, exp_ra:10'h004, exp_rd_gap:6, exp_aw_hi:1, exp_w_hi:1, exp_done:1, exp_err:0};
        vecs[2] = '{dir:1'b1, addr:32'hA5A5_0000, len:26'h3FF_FFFF, aw_dly:3, berr_idx:-1,
                    sr:{32'h0, 32'h0, 32'h1}, exp_nwr:3,
                    exp_wa:{10'h058, 10'h048, 10'h030}, exp_wd:{32'h03FF_FFFF, 32'hA5A5_0000, 32'h1},
                    exp_nrd:1, exp_ra:10'h034, exp_rd_gap:0, exp_aw_hi:4, exp_w_hi:1, exp_done:1, exp_err:0};
        vecs[3] = '{dir:1'b0, addr:32'h0000_8000, len:26'h10, aw_dly:0, berr_idx:1,
                    sr:{32'h0, 32'h0, 32'h2}, exp_nwr:2,
                    exp_wa:{10'h000, 10'h018, 10'h000}, exp_wd:{32'h0, 32'h0000_8000, 32'h1},
                    exp_nrd:0, exp_ra:10'h000, exp_rd_gap:0, exp_aw_hi:1, exp_w_hi:1, exp_done:0, exp_err:1};
        vecs[4] = '{dir:1'b1, addr:32'h3000_0000, len:26'h1, aw_dly:0, berr_idx:-1,
                    sr:{32'h0, 32'h0, 32'h20}, exp_nwr:3,
                    exp_wa:{10'h058, 10'h048, 10'h030}, exp_wd:{32'h1, 32'h3000_0000, 32'h1},
                    exp_nrd:1, exp_ra:10'h034, exp_rd_gap:0, exp_aw_hi:1, exp_w_hi:1, exp_done:0, exp_err:1};
        vecs[5] = '{dir:1'b1, addr:32'h4000_0000, len:26'h0, aw_dly:0, berr_idx:-1,
                    sr:{32'h0, 32'h0, 32'h2}, exp_nwr:0,
                    exp_wa:{10'h000, 10'h000, 10'h000}, exp_wd:{32'h0, 32'h0, 32'h0},
                    exp_nrd:0, exp_ra:10'h000, exp_rd_gap:0, exp_aw_hi:0, exp_w_hi:0, exp_done:0, exp_err:1};
        vecs[6] = '{dir:1'b0, addr:32'h5000_0000, len:26'h100, aw_dly:0, berr_idx:-1,
                    sr:{32'h0, 32'h0, 32'h42}, exp_nwr:3,
                    exp_wa:{10'h028, 10'h018, 10'h000}, exp_wd:{32'h100, 32'h5000_0000, 32'h1},
                    exp_nrd:1, exp_ra:10'h004, exp_rd_gap:0, exp_aw_hi:1, exp_w_hi:1, exp_done:0, exp_err:1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done/err", {bus.done, bus.err}, 2'b00);
        chk("reset valids", {bus.s_axi_lite_awvalid, bus.s_axi_lite_wvalid, bus.s_axi_lite_bready,
                             bus.s_axi_lite_arvalid, bus.s_axi_lite_rready}, 5'b0);
        chk("reset awaddr", bus.s_axi_lite_awaddr, 10'h0);
        chk("reset wdata",  bus.s_axi_lite_wdata, 32'h0);
        chk("reset araddr", bus.s_axi_lite_araddr, 10'h0);

        for (int i = 0; i < 7; i++)
            run_vec(i, $sformatf("v%0d", i));

        // Reset in the middle of a stalled AW handshake.
        clear_logs(50, -1, {32'h0, 32'h0, 32'h2});
        send_cmd(1'b1, 32'h6000_0000, 26'h20);
        t = 0;
        while (!bus.s_axi_lite_awvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("midrst awvalid high", bus.s_axi_lite_awvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst valids", {bus.s_axi_lite_awvalid, bus.s_axi_lite_wvalid, bus.s_axi_lite_bready,
                              bus.s_axi_lite_arvalid, bus.s_axi_lite_rready}, 5'b0);
        chk("midrst cmd_ready", bus.cmd_ready, 1'b1);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst awaddr", bus.s_axi_lite_awaddr, 10'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst cmd_ready", bus.cmd_ready, 1'b1);
        run_vec(0, "r0");

        chk("done with err overlap", viol_de, 0);
        chk("busy vs cmd_ready", viol_busy, 0);
        chk("write/read overlap", viol_ovl, 0);
        chk("bready before aw/w done", viol_b, 0);
        chk("aw/w payload stability", viol_stab, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
